// File: rtl/mvm_4_4_8_1.sv
// Matrix-vector multiplier: loads A (MxN) and x (N), then streams y = A*x using one signed MAC.
// Latency: load M*N (or N) cycles after command; done one cycle after the last MAC, y[0..M-1] on the next M cycles.
// No backpressure: commands are one-cycle pulses; any arriving while busy are dropped.
//
// Ports:
//   clk        - rising-edge clock for all state
//   reset      - asynchronous active-low reset (A/x memories are not cleared)
//   loadMatrix - command: capture M*N elements of A, row-major, on following cycles
//   loadVector - command: capture N elements of x on following cycles
//   start      - command: compute y = A*x with the last loaded A and x
//   done       - one-cycle pulse immediately before the result stream
//   data_in    - signed element input for both loads
//   data_out   - signed 2*T-bit result element, 0 outside the result cycles
module mvm_4_4_8_1 #(
  parameter int M = 4,
  parameter int N = 4,
  parameter int T = 8,
  parameter int P = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  loadMatrix,
  input  logic                  loadVector,
  input  logic                  start,
  output logic                  done,
  input  logic signed [T-1:0]   data_in,
  output logic signed [2*T-1:0] data_out
);

  localparam int DW  = 2 * T;
  localparam int RIW = (M > 1) ? $clog2(M) : 1;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int OW  = $clog2(M + 1);

  // Only a single MAC lane is built; wider P values elaborate to the same datapath.
  if (P != 1) begin : g_single_mac_only
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_M  = 3'd1,
    LOAD_V  = 3'd2,
    COMPUTE = 3'd3,
    OUT     = 3'd4
  } state_t;

  state_t state_q, state_d;

  // row/col walk A and x during loads and compute; out counts the done cycle plus M result cycles.
  logic [RIW-1:0] row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic [OW-1:0]  out_q, out_d;

  logic signed [DW-1:0] y_q [M];
  logic signed [DW-1:0] y_d [M];

  // Operand storage survives reset so a start after reset still sees the last loads.
  logic signed [T-1:0] a_q [M][N];
  logic signed [T-1:0] x_q [N];

  logic                 a_we;
  logic                 x_we;
  logic                 accept;
  logic                 last_col;
  logic                 last_row;
  logic signed [DW-1:0] prod;
  logic [RIW-1:0]       out_idx;

  assign last_col = (col_q == CW'(N - 1));
  assign last_row = (row_q == RIW'(M - 1));

  // Operands are widened before multiplying so the product and sum wrap modulo 2^DW.
  assign prod = DW'(a_q[row_q][col_q]) * DW'(x_q[col_q]);

  // Result cycle k (out_q = k, k>=1) shows y[k-1].
  assign out_idx = RIW'(out_q - OW'(1));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    out_d   = out_q;
    for (int i = 0; i < M; i++) begin
      y_d[i] = y_q[i];
    end
    a_we   = 1'b0;
    x_we   = 1'b0;
    accept = 1'b0;

    unique case (state_q)
      IDLE: begin
        accept = 1'b1;
      end

      LOAD_M: begin
        a_we = 1'b1;
        if (last_col) begin
          col_d = '0;
          if (last_row) begin
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d = row_q + RIW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end

      LOAD_V: begin
        x_we = 1'b1;
        if (last_col) begin
          col_d   = '0;
          state_d = IDLE;
        end else begin
          col_d = col_q + CW'(1);
        end
      end

      COMPUTE: begin
        y_d[row_q] = y_q[row_q] + prod;
        if (last_col) begin
          col_d = '0;
          if (last_row) begin
            row_d   = '0;
            out_d   = '0;
            state_d = OUT;
          end else begin
            row_d = row_q + RIW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end

      OUT: begin
        if (out_q == OW'(M)) begin
          // Last result cycle behaves like IDLE so a new command loses no cycle.
          accept  = 1'b1;
          out_d   = '0;
          state_d = IDLE;
        end else begin
          out_d = out_q + OW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      if (loadMatrix) begin
        state_d = LOAD_M;
        row_d   = '0;
        col_d   = '0;
      end else if (loadVector) begin
        state_d = LOAD_V;
        col_d   = '0;
      end else if (start) begin
        state_d = COMPUTE;
        row_d   = '0;
        col_d   = '0;
        for (int i = 0; i < M; i++) begin
          y_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      out_q   <= '0;
      for (int i = 0; i < M; i++) begin
        y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      out_q   <= out_d;
      for (int i = 0; i < M; i++) begin
        y_q[i] <= y_d[i];
      end
    end
  end

  // Write enables come from the reset-cleared state, so reset stops a load mid-way
  // and leaves the elements already written in place.
  always_ff @(posedge clk) begin
    if (a_we) begin
      a_q[row_q][col_q] <= data_in;
    end
    if (x_we) begin
      x_q[col_q] <= data_in;
    end
  end

  // Outputs decode registered state only, so reset forces them low at once.
  always_comb begin
    done     = 1'b0;
    data_out = '0;
    if (state_q == OUT) begin
      if (out_q == '0) begin
        done = 1'b1;
      end else begin
        data_out = y_q[out_idx];
      end
    end
  end

endmodule

// File: tb/tb_mvm_4_4_8_1.sv
// Bench for mvm_4_4_8_1: directed numeric cases plus randomized command stream
// checked against an arithmetic model of y = A*x (wrapped to 16 bits).
module tb_mvm_4_4_8_1;

  logic               clk        = 1'b0;
  logic               reset      = 1'b0;
  logic               loadMatrix = 1'b0;
  logic               loadVector = 1'b0;
  logic               start      = 1'b0;
  logic               done;
  logic signed [7:0]  data_in    = '0;
  logic signed [15:0] data_out;

  int tests = 0;
  int fails = 0;

  int a_m [4][4];
  int x_m [4];
  int buf_m [16];
  int buf_x [4];
  int ey [4];
  int rst_iter;

  mvm_4_4_8_1 #(4, 4, 8, 1) dut (
    .clk        (clk),
    .reset      (reset),
    .loadMatrix (loadMatrix),
    .loadVector (loadVector),
    .start      (start),
    .done       (done),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_clear();
    loadMatrix = 1'b0;
    loadVector = 1'b0;
    start      = 1'b0;
  endtask

  task automatic rand_cmds();
    loadMatrix = 1'($urandom_range(0, 1));
    loadVector = 1'($urandom_range(0, 1));
    start      = 1'($urandom_range(0, 1));
  endtask

  function automatic int rand_elem();
    return int'($urandom_range(0, 62)) - 31;
  endfunction

  // y[i] = sum_k A[i][k]*x[k], reduced to a signed 16-bit value.
  function automatic void model_y();
    int s;
    logic signed [15:0] w;
    for (int i = 0; i < 4; i++) begin
      s = 0;
      for (int k = 0; k < 4; k++) begin
        s += a_m[i][k] * x_m[k];
      end
      w = 16'(s);
      ey[i] = int'(w);
    end
  endfunction

  // Loads the first n elements of buf_m; n<16 leaves the DUT mid-load.
  task automatic load_matrix(input int n, input bit junk, input bit prio);
    loadMatrix = 1'b1;
    loadVector = prio ? 1'($urandom_range(0, 1)) : 1'b0;
    start      = prio ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    cmd_clear();
    for (int e = 0; e < n; e++) begin
      data_in = 8'(buf_m[e]);
      if (junk) rand_cmds();
      tick();
      a_m[e / 4][e % 4] = buf_m[e];
      chk("load_m_done", done, 0);
    end
    cmd_clear();
  endtask

  task automatic load_vector(input bit junk, input bit prio);
    loadVector = 1'b1;
    start      = prio ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    cmd_clear();
    for (int e = 0; e < 4; e++) begin
      data_in = 8'(buf_x[e]);
      if (junk) rand_cmds();
      tick();
      x_m[e] = buf_x[e];
      chk("load_v_dout", data_out, 0);
    end
    cmd_clear();
  endtask

  // Ends while the DUT shows y[3]; the caller's next command lands on E21.
  task automatic run_start(input int e0, input int e1, input int e2, input int e3, input bit junk);
    int exp_y [4];
    exp_y[0] = e0;
    exp_y[1] = e1;
    exp_y[2] = e2;
    exp_y[3] = e3;
    start = 1'b1;
    tick();
    cmd_clear();
    for (int c = 1; c <= 15; c++) begin
      if (junk) rand_cmds();
      tick();
      chk("mac_done", done, 0);
      chk("mac_dout", data_out, 0);
    end
    if (junk) rand_cmds();
    tick();
    chk("done_pulse", done, 1);
    chk("done_dout", data_out, 0);
    for (int i = 0; i < 4; i++) begin
      if (junk) rand_cmds();
      tick();
      chk("y_out", data_out, exp_y[i]);
      chk("y_done", done, 0);
    end
    cmd_clear();
  endtask

  task automatic pulse_reset();
    cmd_clear();
    reset = 1'b0;
    #2;
    chk("rst_done", done, 0);
    chk("rst_dout", data_out, 0);
    tick();
    chk("rst_hold_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle_check();
    tick();
    chk("idle_done", done, 0);
    chk("idle_dout", data_out, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", done, 0);
    chk("reset_dout", data_out, 0);
    @(negedge clk);
    reset = 1'b1;

    // Identity A, x = [1,-2,3,-4]; the matrix command hits the first edge after release
    for (int e = 0; e < 16; e++) buf_m[e] = (e / 4 == e % 4) ? 1 : 0;
    load_matrix(16, 1'b0, 1'b0);
    buf_x = '{1, -2, 3, -4};
    load_vector(1'b0, 1'b0);
    run_start(1, -2, 3, -4, 1'b0);
    idle_check();

    // All 31 times all -31
    for (int e = 0; e < 16; e++) buf_m[e] = 31;
    load_matrix(16, 1'b0, 1'b0);
    buf_x = '{-31, -31, -31, -31};
    load_vector(1'b0, 1'b0);
    run_start(-3844, -3844, -3844, -3844, 1'b0);

    // Overflow wrap: 4*127*127 = 64516 -> -1020 (back-to-back command at E21)
    for (int e = 0; e < 16; e++) buf_m[e] = 127;
    load_matrix(16, 1'b0, 1'b0);
    buf_x = '{127, 127, 127, 127};
    load_vector(1'b0, 1'b0);
    run_start(-1020, -1020, -1020, -1020, 1'b0);
    for (int e = 0; e < 16; e++) buf_m[e] = -128;
    load_matrix(16, 1'b0, 1'b0);
    buf_x = '{-128, -128, -128, -128};
    load_vector(1'b0, 1'b0);
    run_start(0, 0, 0, 0, 1'b0);

    // Priority: all three commands together must load the matrix
    for (int e = 0; e < 16; e++) buf_m[e] = e - 8;
    loadMatrix = 1'b1;
    loadVector = 1'b1;
    start      = 1'b1;
    tick();
    cmd_clear();
    for (int e = 0; e < 16; e++) begin
      data_in = 8'(buf_m[e]);
      tick();
      a_m[e / 4][e % 4] = buf_m[e];
    end
    buf_x = '{2, -1, 0, 3};
    load_vector(1'b0, 1'b0);
    // rows: [-8,-7,-6,-5] -> -16+7+0-15=-24; [-4..-1] -> -8+3+0-3=-8; [0..3] -> 0-1+0+9=8; [4..7] -> 8-5+0+21=24
    run_start(-24, -8, 8, 24, 1'b0);

    // Memories survive a reset pulse
    pulse_reset();
    run_start(-24, -8, 8, 24, 1'b0);

    // loadVector at E21 accepted; the next start uses the new x
    buf_x = '{1, 1, 1, 1};
    load_vector(1'b0, 1'b0);
    run_start(-26, -10, 6, 22, 1'b0);

    // Reset mid-compute: abandoned, no done afterwards
    start = 1'b1;
    tick();
    cmd_clear();
    repeat (8) tick();
    pulse_reset();
    for (int c = 0; c < 20; c++) idle_check();

    // Randomized command stream with one mid-load reset
    rst_iter = int'($urandom_range(200, 800));
    for (int it = 0; it < 1000; it++) begin
      if (it == rst_iter) begin
        for (int e = 0; e < 16; e++) buf_m[e] = rand_elem();
        load_matrix(int'($urandom_range(1, 15)), 1'b1, 1'b1);
        pulse_reset();
      end
      case ($urandom_range(0, 2))
        0: begin
          for (int e = 0; e < 16; e++) buf_m[e] = rand_elem();
          load_matrix(16, 1'b1, 1'b1);
        end
        1: begin
          for (int e = 0; e < 4; e++) buf_x[e] = rand_elem();
          load_vector(1'b1, 1'b1);
        end
        default: begin
          model_y();
          run_start(ey[0], ey[1], ey[2], ey[3], 1'b1);
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle_check();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mvm_4_4_8_1.md
MVM_4_4_8_1 -- requirements
Module: mvm_4_4_8_1

Interface
REQ-001 SHALL have parameter M, default 4: matrix rows and output vector length.
REQ-002 SHALL have parameter N, default 4: matrix columns and input vector length.
REQ-003 SHALL have parameter T, default 8: input data width in bits, signed.
REQ-004 SHALL have parameter P, default 1: number of parallel multiply-accumulate units; only the default set (4,4,8,1) needs to be supported, in positional order M,N,T,P.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port loadMatrix, input, 1 bit: one-cycle command to load matrix A.
REQ-008 SHALL have port loadVector, input, 1 bit: one-cycle command to load vector x.
REQ-009 SHALL have port start, input, 1 bit: one-cycle command to compute y = A*x.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse preceding the result stream.
REQ-011 SHALL have port data_in, input, T bits signed: matrix or vector element.
REQ-012 SHALL have port data_out, output, 2*T (16) bits signed: result element.
REQ-013 SHALL keep the port order clk, reset, loadMatrix, loadVector, start, done, data_in, data_out.

Function
REQ-014 SHALL use states IDLE, LOAD_M, LOAD_V, COMPUTE, OUT; commands are accepted only in IDLE and in the last OUT cycle, and are ignored elsewhere.
REQ-015 SHALL apply priority loadMatrix > loadVector > start when commands are asserted together.
REQ-016 SHALL, when loadMatrix is sampled at edge E0, capture data_in at edges E1..E16 as A row-major (A[0][0], A[0][1], ..., A[3][3]), then return to IDLE at E16.
REQ-017 SHALL, when loadVector is sampled at E0, capture data_in at E1..E4 as x[0..3], then return to IDLE at E4.
REQ-018 SHALL, when start is sampled at E0, perform 16 MACs on edges E1..E16 using one signed TxT multiplier; y[i] = sum over k of A[i][k]*x[k].
REQ-019 SHALL keep each product and accumulator at 2*T bits, signed two's complement, wrapping modulo 2^16 on overflow.
REQ-020 SHALL drive done high for exactly the one cycle following E16, and low at all other times.
REQ-021 SHALL present y[0] after E17, y[1] after E18, y[2] after E19 and y[3] after E20, each held for one full cycle.
REQ-022 SHALL, in the cycle showing y[3], evaluate commands exactly as in IDLE, so that a command sampled at E21 is accepted with no gap cycle.
REQ-023 SHALL drive data_out to 0 outside the four result cycles.
REQ-024 SHALL retain the A and x memories until they are overwritten by a new load; a start always uses the most recently loaded A and x.
REQ-025 SHALL allow a partial reload of A (interrupted by reset) to leave the already-written elements updated and the rest unchanged.
REQ-026 SHALL produce undefined data_out for a start issued before any load, while the timing remains as specified.

Reset
REQ-027 SHALL, while reset is low, immediately force the state to IDLE, done=0, data_out=0, and clear all counters and accumulators.
REQ-028 SHALL NOT clear the A and x memories on reset.
REQ-029 SHALL, on reset asserted mid-load, mid-compute or mid-output, abandon the operation; no done is produced for an abandoned start.
REQ-030 SHALL accept a command sampled on the first rising edge after reset is released.

Verification
REQ-031 SHALL pass: A=identity, x=[1,-2,3,-4], start -> done one cycle after E16, then data_out = 1, -2, 3, -4 on consecutive cycles.
REQ-032 SHALL pass: all A=31, all x=-31 -> y = -3844 for all four rows.
REQ-033 SHALL pass: all A=127, all x=127 -> y = -1020 (wrap of 64516); all A=-128, all x=-128 -> y = 0.
REQ-034 SHALL pass: load A and x, pulse reset low for one cycle, then start -> results identical to the pre-reset expectation.
REQ-035 SHALL pass: loadVector sampled at the edge right after y[3] -> accepted, and the next start uses the new x.
REQ-036 SHALL pass: 1000 random commands (loadMatrix, loadVector, start), elements in [-31,31], one random mid-sequence reset -> every streamed y matches the model computed from the last loaded A and x.
